axis_byte_downsizer: RTL and testbench

- AXI-Stream width converter: accepts S_TDATA_BYTES-wide beats on a slave port and emits them one byte per beat on a master port.
- Sits directly downstream of a wide AXIS producer, feeding byte-serial consumers such as UART/SPI bridges and byte-oriented parsers.
- Honours tkeep (null bytes removed), preserves packet boundaries (tlast), and carries sideband signals per packet.

---
 rtl/axis_byte_downsizer.sv | 226 ++++++++++++++++++++++
 tb/tb_axis_byte_downsizer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_byte_downsizer.sv
// axis_byte_downsizer: serialises wide AXI-Stream beats into one byte per beat.
// Null lanes are skipped. tlast marks the last kept byte of a tlast beat. Sideband
// fields are copied onto every byte taken from the same source beat. A beat with no
// kept lanes and tlast set produces one null terminator beat (tkeep=0).
module axis_byte_downsizer #(
    parameter int S_TDATA_BYTES = 4,
    parameter int TID_BITS      = 1,
    parameter int TDEST_BITS    = 1,
    parameter int TUSER_BITS    = 1
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       s_tvalid,
    output logic                       s_tready,
    input  logic [8*S_TDATA_BYTES-1:0] s_tdata,
    input  logic [S_TDATA_BYTES-1:0]   s_tstrb,
    input  logic [S_TDATA_BYTES-1:0]   s_tkeep,
    input  logic                       s_tlast,
    input  logic [TID_BITS-1:0]        s_tid,
    input  logic [TDEST_BITS-1:0]      s_tdest,
    input  logic [TUSER_BITS-1:0]      s_tuser,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic [7:0]                 m_tdata,
    output logic                       m_tstrb,
    output logic                       m_tkeep,
    output logic                       m_tlast,
    output logic [TID_BITS-1:0]        m_tid,
    output logic [TDEST_BITS-1:0]      m_tdest,
    output logic [TUSER_BITS-1:0]      m_tuser
);

    localparam int NB = S_TDATA_BYTES;
    localparam logic [NB-1:0] ONE = NB'(1);

    typedef enum logic {
        EMPTY     = 1'b0,
        SERIALISE = 1'b1
    } state_t;

    state_t state_reg, state_next;
    logic   rdy_en_reg;

    // Holding register: one slave beat, keep_reg tracks the lanes not yet emitted
    logic [8*NB-1:0]       data_reg, data_next;
    logic [NB-1:0]         strb_reg, strb_next;
    logic [NB-1:0]         keep_reg, keep_next;
    logic                  last_reg, last_next;
    logic [TID_BITS-1:0]   id_reg, id_next;
    logic [TDEST_BITS-1:0] dest_reg, dest_next;
    logic [TUSER_BITS-1:0] user_reg, user_next;

    // Registered output stage
    logic                  out_valid_reg, out_valid_next;
    logic [7:0]            out_data_reg, out_data_next;
    logic                  out_strb_reg, out_strb_next;
    logic                  out_keep_reg, out_keep_next;
    logic                  out_last_reg, out_last_next;
    logic [TID_BITS-1:0]   out_id_reg, out_id_next;
    logic [TDEST_BITS-1:0] out_dest_reg, out_dest_next;
    logic [TUSER_BITS-1:0] out_user_reg, out_user_next;

    // Lane views of incoming and held data
    logic [7:0] in_lane   [NB];
    logic [7:0] hold_lane [NB];

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign in_lane[gi]   = s_tdata[8*gi +: 8];
            assign hold_lane[gi] = data_reg[8*gi +: 8];
        end
    endgenerate

    // Lowest remaining lane (one-hot) and what is left after emitting it
    logic [NB-1:0] in_first, in_rest, hold_first, hold_rest;
    assign in_first   = s_tkeep & (~s_tkeep + ONE);
    assign in_rest    = s_tkeep & ~in_first;
    assign hold_first = keep_reg & (~keep_reg + ONE);
    assign hold_rest  = keep_reg & ~hold_first;

    logic in_strb_sel, hold_strb_sel;
    assign in_strb_sel   = |(s_tstrb & in_first);
    assign hold_strb_sel = |(strb_reg & hold_first);

    // Handshake qualifiers. s_tready in SERIALISE only opens when the final held lane
    // moves to the output this cycle, so the next beat lands in the holding register
    // with no bubble. None of this looks at s_tvalid.
    logic out_free, accept, bypass, load_hold, load, in_emits;
    assign out_free  = !out_valid_reg || m_tready;
    assign s_tready  = rdy_en_reg &&
                       ((state_reg == EMPTY) || (out_free && (hold_rest == '0)));
    assign accept    = s_tvalid && s_tready;
    // From EMPTY with a free output the first lane goes straight to the output stage
    assign bypass    = accept && (state_reg == EMPTY) && out_free;
    assign load_hold = (state_reg == SERIALISE) && out_free;
    assign in_emits  = (s_tkeep != '0) || s_tlast;
    assign load      = (bypass && in_emits) || load_hold;

    // Pick the byte of the lowest remaining lane (zero for a null beat)
    logic [7:0] in_byte, hold_byte;
    always_comb begin
        in_byte   = '0;
        hold_byte = '0;
        for (int i = 0; i < NB; i++) begin
            if (in_first[i])
                in_byte = in_lane[i];
            if (hold_first[i])
                hold_byte = hold_lane[i];
        end
    end

    // Next state, holding register update and output stage load
    always_comb begin
        state_next     = state_reg;
        data_next      = data_reg;
        strb_next      = strb_reg;
        keep_next      = keep_reg;
        last_next      = last_reg;
        id_next        = id_reg;
        dest_next      = dest_reg;
        user_next      = user_reg;
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        out_strb_next  = out_strb_reg;
        out_keep_next  = out_keep_reg;
        out_last_next  = out_last_reg;
        out_id_next    = out_id_reg;
        out_dest_next  = out_dest_reg;
        out_user_next  = out_user_reg;

        if (load) begin
            out_valid_next = 1'b1;
            if (bypass) begin
                out_data_next = in_byte;
                out_strb_next = in_strb_sel;
                out_keep_next = (s_tkeep != '0);
                out_last_next = s_tlast && (in_rest == '0);
                out_id_next   = s_tid;
                out_dest_next = s_tdest;
                out_user_next = s_tuser;
            end else begin
                out_data_next = hold_byte;
                out_strb_next = hold_strb_sel;
                out_keep_next = (keep_reg != '0);
                out_last_next = last_reg && (hold_rest == '0);
                out_id_next   = id_reg;
                out_dest_next = dest_reg;
                out_user_next = user_reg;
            end
        end else if (m_tready) begin
            out_valid_next = 1'b0;
        end

        if (accept) begin
            data_next = s_tdata;
            strb_next = s_tstrb;
            last_next = s_tlast;
            id_next   = s_tid;
            dest_next = s_tdest;
            user_next = s_tuser;
            if (bypass) begin
                keep_next  = in_rest;
                state_next = (in_rest != '0) ? SERIALISE : EMPTY;
            end else begin
                // A held beat with no lanes but tlast set is the pending null terminator
                keep_next  = s_tkeep;
                state_next = in_emits ? SERIALISE : EMPTY;
            end
        end else if (load_hold) begin
            keep_next  = hold_rest;
            state_next = (hold_rest != '0) ? SERIALISE : EMPTY;
        end
    end

    // State, holding and output registers; reset discards any partial beat
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg     <= EMPTY;
            rdy_en_reg    <= 1'b0;
            data_reg      <= '0;
            strb_reg      <= '0;
            keep_reg      <= '0;
            last_reg      <= 1'b0;
            id_reg        <= '0;
            dest_reg      <= '0;
            user_reg      <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_strb_reg  <= 1'b0;
            out_keep_reg  <= 1'b0;
            out_last_reg  <= 1'b0;
            out_id_reg    <= '0;
            out_dest_reg  <= '0;
            out_user_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            rdy_en_reg    <= 1'b1;
            data_reg      <= data_next;
            strb_reg      <= strb_next;
            keep_reg      <= keep_next;
            last_reg      <= last_next;
            id_reg        <= id_next;
            dest_reg      <= dest_next;
            user_reg      <= user_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_strb_reg  <= out_strb_next;
            out_keep_reg  <= out_keep_next;
            out_last_reg  <= out_last_next;
            out_id_reg    <= out_id_next;
            out_dest_reg  <= out_dest_next;
            out_user_reg  <= out_user_next;
        end
    end

    assign m_tvalid = out_valid_reg;
    assign m_tdata  = out_data_reg;
    assign m_tstrb  = out_strb_reg;
    assign m_tkeep  = out_keep_reg;
    assign m_tlast  = out_last_reg;
    assign m_tid    = out_id_reg;
    assign m_tdest  = out_dest_reg;
    assign m_tuser  = out_user_reg;

endmodule

// File: tb/tb_axis_byte_downsizer.sv
// tb_axis_byte_downsizer: randomized and directed stimulus against a queue-based
// model that expands each accepted beat into its expected byte sequence.
module tb_axis_byte_downsizer;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [31:0] s_tdata = '0;
    logic [3:0]  s_tstrb = '0;
    logic [3:0]  s_tkeep = '0;
    logic        s_tlast = 1'b0;
    logic        s_tid = 1'b0;
    logic        s_tdest = 1'b0;
    logic        s_tuser = 1'b0;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic [7:0]  m_tdata;
    logic        m_tstrb;
    logic        m_tkeep;
    logic        m_tlast;
    logic        m_tid;
    logic        m_tdest;
    logic        m_tuser;

    axis_byte_downsizer #(
        .S_TDATA_BYTES(4),
        .TID_BITS(1),
        .TDEST_BITS(1),
        .TUSER_BITS(1)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .s_tstrb(s_tstrb), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tstrb(m_tstrb), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .m_tid(m_tid), .m_tdest(m_tdest), .m_tuser(m_tuser)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        logic [3:0]  keep;
        logic        last;
        logic        id;
        logic        dest;
        logic        user;
    } beat_t;

    beat_t       in_q[$];
    beat_t       saved[$];
    logic [13:0] exp_q[$];
    int          out_cyc[$];
    int          acc_cyc[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    bit          prev_acc = 1'b0;
    bit          hold_chk = 1'b0;
    logic [13:0] snap = '0;
    beat_t       b;
    int          n;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [13:0] out_vec();
        return {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser};
    endfunction

    function automatic beat_t mk_beat(input logic [31:0] d, input logic [3:0] s,
                                      input logic [3:0] k, input logic l,
                                      input logic i, input logic de, input logic u);
        beat_t r;
        r.data = d; r.strb = s; r.keep = k; r.last = l; r.id = i; r.dest = de; r.user = u;
        return r;
    endfunction

    // Reference: kept lanes in ascending order, tlast on the highest kept lane,
    // a single null beat for an empty tlast beat, nothing for an empty non-last beat.
    task automatic model_beat(input beat_t mb);
        int hi;
        hi = -1;
        for (int i = 0; i < 4; i++)
            if (mb.keep[i]) hi = i;
        if (hi < 0) begin
            if (mb.last)
                exp_q.push_back({8'h00, 1'b0, 1'b0, 1'b1, mb.id, mb.dest, mb.user});
        end else begin
            for (int i = 0; i < 4; i++)
                if (mb.keep[i])
                    exp_q.push_back({mb.data[8*i +: 8], mb.strb[i], 1'b1,
                                     mb.last && (i == hi), mb.id, mb.dest, mb.user});
        end
    endtask

    // One clock: drive at negedge, observe handshakes just after, edge follows
    task automatic step(input int rpct, input int vpct);
        @(negedge aclk);
        cyc++;
        if (prev_acc) s_tvalid = 1'b0;
        prev_acc = 1'b0;
        m_tready = ($urandom_range(99) < rpct);
        if (!s_tvalid && in_q.size() > 0 && $urandom_range(99) < vpct) begin
            s_tdata  = in_q[0].data;
            s_tstrb  = in_q[0].strb;
            s_tkeep  = in_q[0].keep;
            s_tlast  = in_q[0].last;
            s_tid    = in_q[0].id;
            s_tdest  = in_q[0].dest;
            s_tuser  = in_q[0].user;
            s_tvalid = 1'b1;
        end
        #1;
        if (hold_chk) begin
            check("stall_valid", 32'(m_tvalid), 32'd1);
            check("stall_fields", 32'(out_vec()), 32'(snap));
        end
        hold_chk = m_tvalid && !m_tready;
        snap = out_vec();
        if (m_tvalid && m_tready) begin
            out_cyc.push_back(cyc);
            if (exp_q.size() == 0)
                check("extra_beat", 32'(exp_q.size()), 32'd1);
            else
                check("beat", 32'(out_vec()), 32'(exp_q.pop_front()));
        end
        if (s_tvalid && s_tready) begin
            acc_cyc.push_back(cyc);
            model_beat(in_q.pop_front());
            prev_acc = 1'b1;
        end
    endtask

    // Run until everything queued is sent and received, then idle to catch extras
    task automatic run(input int rpct, input int vpct, input int budget);
        int k;
        k = 0;
        while ((in_q.size() > 0 || exp_q.size() > 0 || s_tvalid) && k < budget) begin
            step(rpct, vpct);
            k++;
        end
        check("drain_timeout", 32'(k < budget), 32'd1);
        for (int i = 0; i < 6; i++) step(rpct, 0);
    endtask

    task automatic clear_log();
        out_cyc.delete();
        acc_cyc.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset behaviour
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_mvalid", 32'(m_tvalid), 32'd0);
        check("rst_sready", 32'(s_tready), 32'd0);
        check("rst_fields", 32'(out_vec()), 32'd0);
        areset = 1'b0;
        #1;
        check("rel_sready_low", 32'(s_tready), 32'd0);
        @(posedge aclk);
        #1;
        check("rel_sready_high", 32'(s_tready), 32'd1);

        // 1: single full beat, latency and consecutive output
        clear_log();
        in_q.push_back(mk_beat(32'h44332211, 4'hF, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0));
        run(100, 100, 50);
        check("t1_count", 32'(out_cyc.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            check("t1_cycle", (out_cyc.size() > k && acc_cyc.size() > 0) ?
                  32'(out_cyc[k] - acc_cyc[0]) : 32'hFFFFFFFF, 32'(k + 1));

        // 2: sparse keep
        clear_log();
        in_q.push_back(mk_beat(32'hDDCCBBAA, 4'b1010, 4'b1010, 1'b1, 1'b1, 1'b0, 1'b1));
        run(100, 100, 50);
        check("t2_count", 32'(out_cyc.size()), 32'd2);
        check("t2_gap", (out_cyc.size() == 2) ? 32'(out_cyc[1] - out_cyc[0]) : 32'hFFFFFFFF, 32'd1);

        // 3: four back-to-back full beats at full rate
        clear_log();
        saved.delete();
        for (int k = 0; k < 4; k++) begin
            b = mk_beat($urandom, 4'hF, 4'hF, k == 3, 1'($urandom), 1'($urandom), 1'($urandom));
            saved.push_back(b);
            in_q.push_back(b);
        end
        run(100, 100, 100);
        check("t3_count", 32'(out_cyc.size()), 32'd16);
        for (int k = 1; k < 16; k++)
            check("t3_gapless", (out_cyc.size() > k) ? 32'(out_cyc[k] - out_cyc[k-1]) : 32'hFFFFFFFF, 32'd1);
        check("t3_acc_count", 32'(acc_cyc.size()), 32'd4);
        for (int k = 1; k < 4; k++)
            check("t3_acc_spacing", (acc_cyc.size() > k) ? 32'(acc_cyc[k] - acc_cyc[k-1]) : 32'hFFFFFFFF,
                  (k == 1) ? 32'd3 : 32'd4);

        // 4: same beats with random backpressure
        clear_log();
        foreach (saved[k]) in_q.push_back(saved[k]);
        run(50, 100, 400);
        check("t4_count", 32'(out_cyc.size()), 32'd16);

        // 5: null beats
        clear_log();
        in_q.push_back(mk_beat(32'h12345678, 4'h3, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        run(100, 100, 50);
        check("t5_silent", 32'(out_cyc.size()), 32'd0);
        clear_log();
        in_q.push_back(mk_beat(32'h12345678, 4'h3, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0));
        run(100, 100, 50);
        check("t5_null_count", 32'(out_cyc.size()), 32'd1);

        // Random mixed traffic with random valid and ready
        for (int k = 0; k < 60; k++) begin
            b = mk_beat($urandom, 4'($urandom), ($urandom_range(5) == 0) ? 4'h0 : 4'($urandom),
                        $urandom_range(2) == 0, 1'($urandom), 1'($urandom), 1'($urandom));
            in_q.push_back(b);
        end
        run(60, 70, 2000);

        // 6: reset in the middle of a beat
        clear_log();
        in_q.push_back(mk_beat(32'h88776655, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0));
        n = 0;
        while (out_cyc.size() < 2 && n < 20) begin
            step(100, 100);
            n++;
        end
        check("t6_reach", 32'(out_cyc.size()), 32'd2);
        @(negedge aclk);
        areset = 1'b1;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        @(posedge aclk);
        #1;
        check("t6_mvalid", 32'(m_tvalid), 32'd0);
        check("t6_sready", 32'(s_tready), 32'd0);
        exp_q.delete();
        in_q.delete();
        hold_chk = 1'b0;
        prev_acc = 1'b0;
        @(negedge aclk);
        areset = 1'b0;
        #1;
        check("t6_sready_low", 32'(s_tready), 32'd0);
        @(posedge aclk);
        #1;
        check("t6_sready_up", 32'(s_tready), 32'd1);
        clear_log();
        in_q.push_back(mk_beat(32'h0D0C0B0A, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1));
        run(100, 100, 50);
        check("t6_count", 32'(out_cyc.size()), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
